// File: rtl/aes_encoder.sv
// Fully pipelined AES encryptor: one cipher round per register stage. Each block carries its key.
// Latency NR cycles; accepts a new in/key pair every cycle; no handshake, so it never stalls.
module aes_encoder #(
  parameter int KEY_SIZE = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [127:0]        in,
  input  logic [KEY_SIZE-1:0] key,
  output logic [127:0]        out,
  output logic                valid
);
  localparam int NK = KEY_SIZE / 32;
  localparam int NR = NK + 6;

  if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
    $error("aes_encoder: KEY_SIZE must be 128, 192 or 256");
  end

  // Byte x of the table sits at bits [8*(255-x)+7 -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] rc;
    case (j)
      1:       rc = 8'h01;
      2:       rc = 8'h02;
      3:       rc = 8'h04;
      4:       rc = 8'h08;
      5:       rc = 8'h10;
      6:       rc = 8'h20;
      7:       rc = 8'h40;
      8:       rc = 8'h80;
      9:       rc = 8'h1b;
      10:      rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Index of the newest schedule word held after round r; the window is always NK words wide.
  function automatic int win_end(input int r);
    return (4 * r + 3 > NK - 1) ? 4 * r + 3 : NK - 1;
  endfunction

  // Slide the NK-word schedule window forward by count words, first new word index first_idx.
  function automatic logic [KEY_SIZE-1:0] expand_win(input logic [KEY_SIZE-1:0] win_in,
                                                     input int first_idx, input int count);
    logic [KEY_SIZE-1:0] w;
    logic [31:0]         temp;
    w = win_in;
    for (int j = 0; j < 4; j++) begin
      if (j < count) begin
        temp = w[31:0];
        if ((first_idx + j) % NK == 0) begin
          temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon((first_idx + j) / NK), 24'h0};
        end else if (NK > 6 && (first_idx + j) % NK == 4) begin
          temp = sub_word(temp);
        end
        w = {w[KEY_SIZE-33:0], w[KEY_SIZE-1 -: 32] ^ temp};
      end
    end
    return w;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    // ShiftRows: row w of column c comes from column (c + w) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) t[w + 4*c] = b[w + 4*((c + w) % 4)];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) begin
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return r ^ rk;
  endfunction

  logic [127:0]        st_d      [1:NR];
  logic [127:0]        st_q      [1:NR];
  logic [KEY_SIZE-1:0] kw_d      [1:NR-1];
  logic [KEY_SIZE-1:0] kw_q      [1:NR-1];
  logic [KEY_SIZE-1:0] key_src   [1:NR];
  logic [127:0]        state_src [1:NR];
  logic [KEY_SIZE-1:0] win       [1:NR];
  logic [NR-1:0]       valid_d;
  logic [NR-1:0]       valid_q;
  logic                unused_win;

  always_comb begin
    key_src      = '{default: '0};
    state_src    = '{default: '0};
    key_src[1]   = key;
    state_src[1] = in ^ key[KEY_SIZE-1 -: 128];
    for (int k = 2; k <= NR; k++) begin
      key_src[k]   = kw_q[k-1];
      state_src[k] = st_q[k-1];
    end
  end

  always_comb begin
    win  = '{default: '0};
    st_d = '{default: '0};
    kw_d = '{default: '0};
    for (int k = 1; k <= NR; k++) begin
      win[k]  = expand_win(key_src[k], win_end(k - 1) + 1, win_end(k) - win_end(k - 1));
      st_d[k] = aes_round(state_src[k],
                          win[k][KEY_SIZE-1-32*(4*k-win_end(k)+NK-1) -: 128], k == NR);
    end
    for (int k = 1; k < NR; k++) kw_d[k] = win[k];
    valid_d = {valid_q[NR-2:0], 1'b1};
  end

  // The last stage only needs its round key; the rest of its schedule window is dropped.
  assign unused_win = ^win[NR];

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= '{default: '0};
      kw_q    <= '{default: '0};
      valid_q <= '0;
    end else begin
      st_q    <= st_d;
      kw_q    <= kw_d;
      valid_q <= valid_d;
    end
  end

  assign out   = st_q[NR];
  assign valid = valid_q[NR-1];

endmodule

// File: tb/tb_aes_encoder.sv
// Scoreboard bench for aes_encoder at all three key sizes, driven in lockstep from one stream.
module tb_aes_encoder;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K1   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [383:0] KAT1 = {128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                   128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                   128'h8ea2b7ca516745bfeafc49904b496089};
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K2   = 256'h2b7e151628aed2a6abf7158809cf4f3c0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [383:0] KAT2 = {128'h3925841d02dc09fbdc118597196a0b32, 256'h0};

  typedef struct {
    logic [127:0] dat;
    int           due;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] pt;
  logic [255:0] key_full;
  logic [127:0] out128, out192, out256;
  logic         vld128, vld192, vld256;
  logic         rst_at_edge = 1'b0;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  exp_t         sb_q [3][$];
  logic [7:0]   sb_m [256];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  aes_encoder #(.KEY_SIZE(128)) u_aes128 (
    .clock(clock), .reset(reset), .in(pt), .key(key_full[255:128]), .out(out128), .valid(vld128));
  aes_encoder #(.KEY_SIZE(192)) u_aes192 (
    .clock(clock), .reset(reset), .in(pt), .key(key_full[255:64]), .out(out192), .valid(vld192));
  aes_encoder #(.KEY_SIZE(256)) u_aes256 (
    .clock(clock), .reset(reset), .in(pt), .key(key_full), .out(out256), .valid(vld256));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv, f, acc;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    f   = inv;
    acc = inv;
    for (int n = 0; n < 4; n++) begin
      f   = {f[6:0], f[7]};
      acc = acc ^ f;
    end
    return acc ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] p, input logic [255:0] k,
                                             input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = p[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sb_m[s[(b % 4) + 4 * (((b / 4) + (b % 4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (r == nr) begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end else begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Compare this cycle's outputs of all three instances against the scoreboard heads.
  task automatic observe();
    logic [127:0] got;
    logic         got_v, exp_v;
    exp_t         e;
    for (int i = 0; i < 3; i++) begin
      got   = (i == 0) ? out128 : (i == 1) ? out192 : out256;
      got_v = (i == 0) ? vld128 : (i == 1) ? vld192 : vld256;
      exp_v = (sb_q[i].size() != 0) && (sb_q[i][0].due == cyc);
      chk($sformatf("aes%0d valid", 128 + 64 * i), {127'b0, got_v}, {127'b0, exp_v});
      if (rst_at_edge) chk($sformatf("aes%0d reset out", 128 + 64 * i), got, 128'h0);
      if (exp_v) begin
        e = sb_q[i].pop_front();
        if (got_v) chk($sformatf("aes%0d out", 128 + 64 * i), got, e.dat);
      end
    end
  endtask

  // Present one in/key pair for the next rising edge; kat_m selects fixed expected values.
  task automatic drive(input logic rst, input logic [127:0] p, input logic [255:0] k,
                       input logic [2:0] kat_m, input logic [383:0] kat);
    exp_t e;
    reset    = rst;
    pt       = p;
    key_full = k;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        sb_q[i].delete();
      end else begin
        e.dat = kat_m[i] ? kat[383-128*i -: 128] : aes_model(p, k, 4 + 2 * i);
        e.due = cyc + 10 + 2 * i;
        sb_q[i].push_back(e);
      end
    end
    rst_at_edge = rst;
    @(negedge clock);
    observe();
  endtask

  initial begin
    reset    = 1'b1;
    pt       = '0;
    key_full = '0;
    for (int x = 0; x < 256; x++) sb_m[x] = sbox_calc(x[7:0]);

    for (int n = 0; n < 3; n++) drive(1'b1, rnd128(), {rnd128(), rnd128()}, 3'b000, '0);

    for (int n = 0; n < 20; n++) begin
      if (n % 2 == 0) drive(1'b0, PT1, K1, 3'b111, KAT1);
      else            drive(1'b0, PT2, K2, 3'b001, KAT2);
    end

    for (int n = 0; n < 5; n++) drive(1'b0, rnd128(), {rnd128(), rnd128()}, 3'b000, '0);
    drive(1'b1, rnd128(), {rnd128(), rnd128()}, 3'b000, '0);
    for (int n = 0; n < 20; n++) drive(1'b0, rnd128(), {rnd128(), rnd128()}, 3'b000, '0);

    for (int i = 0; i < 128; i++) begin
      drive(1'b0, PT1 ^ (128'd1 << i), K2, 3'b000, '0);
      drive(1'b0, PT1 ^ (128'd1 << i), ~K2, 3'b000, '0);
    end

    for (int n = 0; n < 16; n++) drive(1'b0, rnd128(), {rnd128(), rnd128()}, 3'b000, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
